// File: rtl/alu_spi_pkg.sv
// Shared definitions for the SPI-attached ALU: opcodes, frame sizes and master FSM encoding.
package alu_spi_pkg;

  localparam int OP_W       = 4;
  localparam int DATA_W     = 32;
  localparam int WRITE_BITS = OP_W + 2 * DATA_W;
  localparam int READ_BITS  = DATA_W;

  localparam logic [OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB = 4'd1;
  localparam logic [OP_W-1:0] OP_AND = 4'd2;
  localparam logic [OP_W-1:0] OP_OR  = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR = 4'd4;
  localparam logic [OP_W-1:0] OP_NOT = 4'd5;
  localparam logic [OP_W-1:0] OP_SHL = 4'd6;
  localparam logic [OP_W-1:0] OP_SHR = 4'd7;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_SETUP = 3'd1;
  localparam state_t ST_WRITE = 3'd2;
  localparam state_t ST_TURN  = 3'd3;
  localparam state_t ST_READ  = 3'd4;
  localparam state_t ST_DONE  = 3'd5;

  // Index of the final bit of the current frame direction.
  function automatic logic [6:0] last_bit_idx(input logic reading);
    return reading ? 7'(READ_BITS - 1) : 7'(WRITE_BITS - 1);
  endfunction

endpackage

// File: rtl/alu_spi_if.sv
// Four-wire SPI bus between the ALU master and the ALU slave.
interface alu_spi_if;
  logic sclk;
  logic mosi;
  logic miso;
  logic nss;

  modport MASTER (output sclk, output mosi, output nss, input miso);
  modport SLAVE  (input sclk, input mosi, input nss, output miso);
endinterface

// File: rtl/alu_spi_master_phase.sv
// SCLK generator and bit counter; each bit is one high cycle followed by one low cycle.
module spi_master_phase import alu_spi_pkg::*; (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       launch,
  input  logic       run,
  input  logic [6:0] bit_last,
  output logic       sclk,
  output logic       last_bit
);

  logic       sclk_r;
  logic [6:0] bit_cnt_r;

  assign last_bit = (bit_cnt_r == bit_last);
  assign sclk     = sclk_r;

  // Toggle sclk while running; the count advances at the end of each low half, never past the last bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sclk_r    <= 1'b0;
      bit_cnt_r <= 7'd0;
    end else if (clear) begin
      sclk_r    <= 1'b0;
      bit_cnt_r <= 7'd0;
    end else if (launch) begin
      sclk_r <= 1'b1;
    end else if (run) begin
      sclk_r <= ~sclk_r;
      if (!sclk_r && !last_bit) begin
        bit_cnt_r <= bit_cnt_r + 7'd1;
      end
    end
  end

endmodule

// File: rtl/alu_spi_master.sv
// SPI master for the ALU slave: sends opcode + operands MSB first, then reads back the 32-bit result.
module alu_spi_master import alu_spi_pkg::*; #(
  parameter int NSS_GAP = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [OP_W-1:0]   opcode,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  alu_spi_if.MASTER         spi_if
);

  localparam int GAP_W = (NSS_GAP < 2) ? 1 : $clog2(NSS_GAP + 1);

  state_t                  state_r;
  logic [WRITE_BITS-1:0]   tx_r;
  logic [READ_BITS-1:0]    rx_r;
  logic                    mosi_r;
  logic                    nss_r;
  logic                    busy_r;
  logic                    done_r;
  logic [DATA_W-1:0]       result_r;
  logic [GAP_W-1:0]        gap_r;

  logic                    accept_s;
  logic                    clear_s;
  logic                    launch_s;
  logic                    run_s;
  logic                    sclk_s;
  logic                    last_bit_s;
  logic [6:0]              bit_last_s;

  assign accept_s   = (state_r == ST_IDLE) && start && (gap_r == '0);
  assign bit_last_s = last_bit_idx(state_r == ST_READ);

  // Phase control: SETUP and TURN launch a high half so both WRITE and READ open with sclk=1.
  always_comb begin
    clear_s  = 1'b0;
    launch_s = 1'b0;
    run_s    = 1'b0;
    case (state_r)
      ST_SETUP: launch_s = 1'b1;
      ST_TURN:  launch_s = 1'b1;
      ST_WRITE: begin
        run_s   = 1'b1;
        clear_s = !sclk_s && last_bit_s;
      end
      ST_READ: begin
        run_s   = 1'b1;
        clear_s = !sclk_s && last_bit_s;
      end
      default:  clear_s = 1'b1;
    endcase
  end

  spi_master_phase u_phase (
    .clock    (clock),
    .reset    (reset),
    .clear    (clear_s),
    .launch   (launch_s),
    .run      (run_s),
    .bit_last (bit_last_s),
    .sclk     (sclk_s),
    .last_bit (last_bit_s)
  );

  // Transaction FSM with tx/rx shift registers; mosi always shows the bit for the next high half.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      tx_r     <= '0;
      rx_r     <= '0;
      mosi_r   <= 1'b0;
      nss_r    <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= '0;
      gap_r    <= '0;
    end else begin
      done_r <= 1'b0;
      if (gap_r != '0) begin
        gap_r <= gap_r - GAP_W'(1);
      end
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            tx_r    <= {opcode, operand_a, operand_b};
            rx_r    <= '0;
            mosi_r  <= opcode[OP_W-1];
            nss_r   <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= ST_SETUP;
          end
        end
        ST_SETUP: state_r <= ST_WRITE;
        ST_WRITE: begin
          if (sclk_s) begin
            tx_r   <= {tx_r[WRITE_BITS-2:0], 1'b0};
            mosi_r <= tx_r[WRITE_BITS-2];
          end else if (last_bit_s) begin
            mosi_r  <= 1'b0;
            state_r <= ST_TURN;
          end
        end
        ST_TURN: state_r <= ST_READ;
        ST_READ: begin
          if (sclk_s) begin
            rx_r <= {rx_r[READ_BITS-2:0], spi_if.miso};
          end else if (last_bit_s) begin
            nss_r    <= 1'b1;
            done_r   <= 1'b1;
            result_r <= rx_r;
            gap_r    <= GAP_W'(NSS_GAP);
            state_r  <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          nss_r   <= 1'b1;
          mosi_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign spi_if.sclk = sclk_s;
  assign spi_if.mosi = mosi_r;
  assign spi_if.nss  = nss_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign result      = result_r;

endmodule
